// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared types and constants for the seven-segment scan controller.
//   seg_t        : active-low segment vector, bit 6 = segment a, bit 0 = segment g
//   SEG_BLANK    : all segments off
//   scan_state_e : BLANK (gap between digit slots) / DRIVE (digit lit)
//   HEX_TABLE    : hex nibble to active-low segment pattern
//   hex_to_seg() : table lookup helper
// -----------------------------------------------------------------------------
package seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b111_1111;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

  // Index 0 is the first entry; patterns are active-low a..g.
  localparam seg_t HEX_TABLE [0:15] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111,  // 7
    7'b0000000,  // 8
    7'b0000100,  // 9
    7'b0001000,  // A
    7'b1100000,  // b
    7'b0110001,  // C
    7'b1000010,  // d
    7'b0110000,  // E
    7'b0111000   // F
  };

  function automatic seg_t hex_to_seg(input logic [3:0] nibble);
    return HEX_TABLE[nibble];
  endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// -----------------------------------------------------------------------------
// seg_hex_decoder
// Purely combinational hex nibble to seven-segment (active-low) decoder.
// Ports:
//   value : 4-bit hex digit
//   seg   : active-low segments, bit 6 = a ... bit 0 = g
// -----------------------------------------------------------------------------
module seg_hex_decoder
  import seg_pkg::*;
(
  input  logic [3:0] value,
  output seg_t       seg
);

  assign seg = hex_to_seg(value);

endmodule

// File: rtl/seg_scan_controller.sv
// -----------------------------------------------------------------------------
// seg_scan_controller
// Time-multiplexed driver for an N-digit common-anode seven-segment display.
// Each digit owns a slot of REFRESH_DIV cycles; the first BLANK_CYCLES of every
// slot keep all anodes off to avoid ghosting. New display contents arrive over
// a valid/ready handshake and are only applied at the end of a full scan, so a
// frame is never drawn with a mix of old and new digits.
//
// Parameters:
//   NUM_DIGITS   : digits scanned (1..8)
//   REFRESH_DIV  : clock cycles per digit slot
//   BLANK_CYCLES : blank cycles at the start of each slot (1..REFRESH_DIV-1)
//
// Ports:
//   clock        : system clock, rising edge
//   reset        : asynchronous, active-high
//   update_valid : producer offers new digit data
//   update_ready : high when no update is waiting for the frame boundary
//   digit_value  : hex nibble per digit, digit i = [4i+3:4i], digit 0 rightmost
//   digit_enable : per-digit enable, 0 = digit dark
//   anode        : active-low digit select, bit i = digit i (registered)
//   cathode      : active-low segments a..g (registered)
//   frame_done   : one-cycle pulse after the last slot of each scan
//
// Optional build macro SEG_SCAN_DP_EN adds:
//   digit_dp     : per-digit decimal point, captured with digit_value
//   dp           : active-low decimal point output (registered like cathode)
// -----------------------------------------------------------------------------
module seg_scan_controller
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    update_valid,
  output logic                    update_ready,
  input  logic [4*NUM_DIGITS-1:0] digit_value,
  input  logic [NUM_DIGITS-1:0]   digit_enable,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              cathode,
  output logic                    frame_done
`ifdef SEG_SCAN_DP_EN
  ,
  input  logic [NUM_DIGITS-1:0]   digit_dp,
  output logic                    dp
`endif
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0]      CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = '1;

  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;

  logic [4*NUM_DIGITS-1:0] display_value;
  logic [NUM_DIGITS-1:0]   display_enable;
  logic [4*NUM_DIGITS-1:0] pending_value;
  logic [NUM_DIGITS-1:0]   pending_enable;
  logic                    pending_valid;

  scan_state_e             state;
  logic                    slot_end;
  logic                    frame_end;
  logic                    transfer;
  logic                    load_direct;
  logic                    load_pending;
  logic                    capture;

  logic [3:0]              sel_value;
  seg_t                    sel_seg;
  logic [NUM_DIGITS-1:0]   anode_next;
  seg_t                    cathode_next;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);

  assign update_ready = ~pending_valid;
  assign transfer     = update_valid && update_ready;

  // A transfer landing exactly on the frame boundary goes straight to the
  // display; otherwise it parks in pending until the next boundary. Ready is
  // low whenever pending is full, so both cases never happen together.
  assign load_direct  = frame_end && transfer;
  assign load_pending = frame_end && pending_valid;
  assign capture      = transfer && !frame_end;

  assign sel_value = display_value[idx*4 +: 4];

  seg_hex_decoder u_hex_decoder (
    .value (sel_value),
    .seg   (sel_seg)
  );

  // Slot counter and digit index: idx advances each time cnt wraps.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Scan state follows the slot position; it decides what the next
  // registered anode/cathode values are. A disabled digit keeps its anode
  // off but the cathode still carries its decoded pattern.
  always_comb begin
    state        = BLANK;
    anode_next   = ANODE_OFF;
    cathode_next = SEG_BLANK;
    if (cnt >= CNT_BLANK) begin
      state = DRIVE;
    end
    if (state == DRIVE) begin
      if (display_enable[idx]) begin
        anode_next = ~(NUM_DIGITS'(1) << idx);
      end
      cathode_next = sel_seg;
    end
  end

  // Outputs are registered from the pre-edge position, giving one cycle of
  // latency and no combinational path from inputs to pins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      anode      <= ANODE_OFF;
      cathode    <= SEG_BLANK;
      frame_done <= 1'b0;
    end else begin
      anode      <= anode_next;
      cathode    <= cathode_next;
      frame_done <= frame_end;
    end
  end

  // Pending buffer and display registers; the display only changes at the
  // frame boundary so a scan is never torn.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      display_value  <= '0;
      display_enable <= '0;
      pending_value  <= '0;
      pending_enable <= '0;
      pending_valid  <= 1'b0;
    end else begin
      if (load_direct) begin
        display_value  <= digit_value;
        display_enable <= digit_enable;
      end else if (load_pending) begin
        display_value  <= pending_value;
        display_enable <= pending_enable;
      end

      if (capture) begin
        pending_value  <= digit_value;
        pending_enable <= digit_enable;
        pending_valid  <= 1'b1;
      end else if (load_pending) begin
        pending_valid  <= 1'b0;
      end
    end
  end

`ifdef SEG_SCAN_DP_EN
  logic [NUM_DIGITS-1:0] display_dp;
  logic [NUM_DIGITS-1:0] pending_dp;
  logic                  dp_next;

  // Decimal point follows the same blank/drive timing as the segments.
  always_comb begin
    dp_next = 1'b1;
    if (state == DRIVE) begin
      dp_next = ~display_dp[idx];
    end
  end

  // Decimal-point storage travels with the digit data through pending.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      display_dp <= '0;
      pending_dp <= '0;
      dp         <= 1'b1;
    end else begin
      dp <= dp_next;
      if (load_direct) begin
        display_dp <= digit_dp;
      end else if (load_pending) begin
        display_dp <= pending_dp;
      end
      if (capture) begin
        pending_dp <= digit_dp;
      end
    end
  end
`endif

endmodule

// File: tb/tb_seg_scan_controller.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_controller
// Self-checking bench for seg_scan_controller with NUM_DIGITS=2,
// REFRESH_DIV=8, BLANK_CYCLES=2. A reference model predicts every output from
// the absolute cycle position within the frame; directed sequences and a
// decode table cover the corner cases, then randomized traffic runs against
// the model. Honours SEG_SCAN_DP_EN when defined.
// -----------------------------------------------------------------------------
module tb_seg_scan_controller;

  localparam int ND    = 2;
  localparam int RD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = ND * RD;

  logic       clock = 1'b0;
  logic       reset;
  logic       update_valid;
  logic       update_ready;
  logic [7:0] digit_value;
  logic [1:0] digit_enable;
  logic [1:0] digit_dp;
  logic [1:0] anode;
  logic [6:0] cathode;
  logic       frame_done;
`ifdef SEG_SCAN_DP_EN
  logic       dp;
`endif

  always #5 clock = ~clock;

  seg_scan_controller #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .update_valid (update_valid),
    .update_ready (update_ready),
    .digit_value  (digit_value),
    .digit_enable (digit_enable),
    .anode        (anode),
    .cathode      (cathode),
    .frame_done   (frame_done)
`ifdef SEG_SCAN_DP_EN
    ,
    .digit_dp     (digit_dp),
    .dp           (dp)
`endif
  );

  int n_compared;
  int n_mismatch;

  // Reference model state
  int         m_pos;
  logic [7:0] m_val, p_val;
  logic [1:0] m_en, p_en, m_dp, p_dp;
  bit         m_pend;
  logic [1:0] e_anode;
  logic [6:0] e_cath;
  logic       e_fd, e_ready, e_dp;

  // Per-frame observation counters filled by scan_frame
  int hits0, hits1, blanks, dark1, dp_low_d0, dp_low_other;

  typedef struct {
    logic [7:0] value;
    logic [1:0] enable;
    logic [1:0] anode0;
    logic [6:0] cath0;
    logic [1:0] anode1;
    logic [6:0] cath1;
  } vec_t;

  vec_t vecs [8];

  function automatic logic [6:0] ref_decode(input logic [3:0] h);
    case (h)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;
      4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;
      4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatch++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] value,
                               input logic [1:0] en, input logic [1:0] dpv);
    update_valid = valid;
    digit_value  = value;
    digit_enable = en;
    digit_dp     = dpv;
  endtask

  task automatic model_reset();
    m_pos   = 0;
    m_val   = '0;
    m_en    = '0;
    m_dp    = '0;
    p_val   = '0;
    p_en    = '0;
    p_dp    = '0;
    m_pend  = 0;
    e_anode = 2'b11;
    e_cath  = 7'h7F;
    e_fd    = 1'b0;
    e_ready = 1'b1;
    e_dp    = 1'b1;
  endtask

  // Predicts the outputs registered by this edge from the frame position,
  // then applies the handshake / frame-boundary update rules.
  task automatic model_edge();
    int p, slot, off;
    logic [3:0] nib;
    bit xfer;
    p    = m_pos % FRAME;
    slot = p / RD;
    off  = p % RD;
    nib  = 4'(m_val >> (4 * slot));
    if (off < BC) begin
      e_anode = 2'b11;
      e_cath  = 7'h7F;
      e_dp    = 1'b1;
    end else begin
      e_anode = 2'b11;
      if (m_en[slot]) e_anode[slot] = 1'b0;
      e_cath = ref_decode(nib);
      e_dp   = ~m_dp[slot];
    end
    e_fd = (p == FRAME - 1);
    xfer = update_valid && !m_pend;
    if (p == FRAME - 1) begin
      if (xfer) begin
        m_val = digit_value; m_en = digit_enable; m_dp = digit_dp;
      end else if (m_pend) begin
        m_val = p_val; m_en = p_en; m_dp = p_dp;
      end
      m_pend = 0;
    end else if (xfer) begin
      p_val = digit_value; p_en = digit_enable; p_dp = digit_dp;
      m_pend = 1;
    end
    m_pos++;
    e_ready = !m_pend;
  endtask

  task automatic step();
    @(posedge clock);
    if (reset) model_reset();
    else model_edge();
    @(negedge clock);
    checkOutput("anode", 32'(anode), 32'(e_anode));
    checkOutput("cathode", 32'(cathode), 32'(e_cath));
    checkOutput("frame_done", 32'(frame_done), 32'(e_fd));
    checkOutput("update_ready", 32'(update_ready), 32'(e_ready));
`ifdef SEG_SCAN_DP_EN
    checkOutput("dp", 32'(dp), 32'(e_dp));
`endif
  endtask

  task automatic push(input logic [7:0] value, input logic [1:0] en, input logic [1:0] dpv);
    bit ok;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (update_ready === 1'b1) ok = 1;
      else step();
    end
    checkOutput("push_ready_wait", 32'(ok), 32'd1);
    applyStimulus(1'b1, value, en, dpv);
    step();
    applyStimulus(1'b0, value, en, dpv);
  endtask

  task automatic wait_frame();
    bit found;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (frame_done === 1'b1) found = 1;
    end
    checkOutput("frame_wait", 32'(found), 32'd1);
  endtask

  // Observes one full frame starting right after a frame_done sample.
  task automatic scan_frame(input string tag, input logic [1:0] an0, input logic [6:0] c0,
                            input logic [1:0] an1, input logic [6:0] c1);
    hits0 = 0; hits1 = 0; blanks = 0; dark1 = 0; dp_low_d0 = 0; dp_low_other = 0;
    for (int j = 0; j < FRAME; j++) begin
      step();
      if ((j % RD) < BC) begin
        if (anode === 2'b11 && cathode === 7'h7F) blanks++;
      end else if (j < RD) begin
        if (anode === an0 && cathode === c0) hits0++;
      end else begin
        if (anode === an1 && cathode === c1) hits1++;
      end
      if (j >= RD && anode === 2'b11) dark1++;
`ifdef SEG_SCAN_DP_EN
      if (dp === 1'b0) begin
        if (j >= BC && j < RD) dp_low_d0++;
        else dp_low_other++;
      end
`endif
    end
    checkOutput({tag, "_digit0"}, 32'(hits0), 32'd6);
    checkOutput({tag, "_digit1"}, 32'(hits1), 32'd6);
    checkOutput({tag, "_blank"}, 32'(blanks), 32'd4);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got time limit reached, expected run to complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lit, old_shown;

    vecs[0] = '{8'h10, 2'b11, 2'b10, 7'b0000001, 2'b01, 7'b1001111};
    vecs[1] = '{8'h32, 2'b11, 2'b10, 7'b0010010, 2'b01, 7'b0000110};
    vecs[2] = '{8'h54, 2'b01, 2'b10, 7'b1001100, 2'b11, 7'b0100100};
    vecs[3] = '{8'h76, 2'b10, 2'b11, 7'b0100000, 2'b01, 7'b0001111};
    vecs[4] = '{8'h98, 2'b11, 2'b10, 7'b0000000, 2'b01, 7'b0000100};
    vecs[5] = '{8'hBA, 2'b11, 2'b10, 7'b0001000, 2'b01, 7'b1100000};
    vecs[6] = '{8'hDC, 2'b00, 2'b11, 7'b0110001, 2'b11, 7'b1000010};
    vecs[7] = '{8'hFE, 2'b11, 2'b10, 7'b0110000, 2'b01, 7'b0111000};

    n_compared = 0;
    n_mismatch = 0;
    reset = 1'b1;
    applyStimulus(1'b0, 8'h00, 2'b00, 2'b00);
    model_reset();
    repeat (3) @(negedge clock);
    checkOutput("rst_anode", 32'(anode), 32'h3);
    checkOutput("rst_cathode", 32'(cathode), 32'h7F);
    checkOutput("rst_frame_done", 32'(frame_done), 32'h0);
    checkOutput("rst_ready", 32'(update_ready), 32'h1);
    reset = 1'b0;

    $display("[TB] frame pulse from reset");
    for (int k = 1; k <= 50; k++) begin
      step();
      checkOutput("frame_pulse", 32'(frame_done), 32'((k % FRAME) == 0));
    end

    $display("[TB] basic scan 8'h21");
    push(8'h21, 2'b11, 2'b00);
    wait_frame();
    scan_frame("basic", 2'b10, 7'b1001111, 2'b01, 7'b0010010);

    $display("[TB] tear-free update 8'hAF");
    repeat (5) step();
    applyStimulus(1'b1, 8'hAF, 2'b11, 2'b00);
    step();
    checkOutput("tear_ready_low", 32'(update_ready), 32'h0);
    applyStimulus(1'b0, 8'hAF, 2'b11, 2'b00);
    old_shown = 0;
    for (int j = 6; j < FRAME; j++) begin
      step();
      if (j >= RD + BC && anode === 2'b01 && cathode === 7'b0010010) old_shown++;
    end
    checkOutput("tear_old_digit1", 32'(old_shown), 32'd6);
    checkOutput("tear_boundary_pulse", 32'(frame_done), 32'h1);
    checkOutput("tear_ready_back", 32'(update_ready), 32'h1);
    scan_frame("tear_new", 2'b10, 7'b0111000, 2'b01, 7'b0001000);

    $display("[TB] boundary collision 8'h3C");
    repeat (FRAME - 1) step();
    applyStimulus(1'b1, 8'h3C, 2'b11, 2'b00);
    checkOutput("coll_ready_before", 32'(update_ready), 32'h1);
    step();
    checkOutput("coll_pulse", 32'(frame_done), 32'h1);
    checkOutput("coll_ready_edge", 32'(update_ready), 32'h1);
    applyStimulus(1'b0, 8'h3C, 2'b11, 2'b00);
    scan_frame("collision", 2'b10, 7'b0110001, 2'b01, 7'b0000110);

    $display("[TB] digit disable");
    push(8'h57, 2'b01, 2'b01);
    wait_frame();
    scan_frame("disable", 2'b10, 7'b0001111, 2'b11, 7'b0100100);
    checkOutput("disable_dark_slot1", 32'(dark1), 32'd8);
`ifdef SEG_SCAN_DP_EN
    checkOutput("dp_digit0_drive", 32'(dp_low_d0), 32'd6);
    checkOutput("dp_elsewhere", 32'(dp_low_other), 32'd0);
`endif

    $display("[TB] decode table");
    for (int i = 0; i < 8; i++) begin
      push(vecs[i].value, vecs[i].enable, 2'b00);
      wait_frame();
      scan_frame($sformatf("vec%0d", i), vecs[i].anode0, vecs[i].cath0,
                 vecs[i].anode1, vecs[i].cath1);
    end

    $display("[TB] reset mid-scan with pending update");
    repeat (4) step();
    push(8'h11, 2'b11, 2'b11);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rst_async_anode", 32'(anode), 32'h3);
    checkOutput("rst_async_cathode", 32'(cathode), 32'h7F);
    checkOutput("rst_async_ready", 32'(update_ready), 32'h1);
    checkOutput("rst_async_frame_done", 32'(frame_done), 32'h0);
    model_reset();
    repeat (2) step();
    reset = 1'b0;
    step();
    checkOutput("rst_release_anode1", 32'(anode), 32'h3);
    step();
    checkOutput("rst_release_anode2", 32'(anode), 32'h3);
    lit = 0;
    repeat (30) begin
      step();
      if (anode !== 2'b11) lit++;
    end
    checkOutput("rst_pending_dropped", 32'(lit), 32'd0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) begin
      if (!(update_valid === 1'b1 && update_ready !== 1'b1)) begin
        applyStimulus($urandom_range(0, 3) == 0, 8'($urandom), 2'($urandom), 2'($urandom));
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
